// File: rtl/fft_pkg.sv
// Shared FSM type, default sizing and configuration checks for the ping-pong FFT
// address generator. Instances derive their own widths from their LOG_N_MAX.
package fft_pkg;

  localparam int LOG_N_MAX_DEF = 10;
  localparam int BFLY_LAT_DEF  = 4;
  localparam int ADDR_W        = LOG_N_MAX_DEF;
  localparam int TW_W          = LOG_N_MAX_DEF - 1;
  localparam int LOGN_W        = $clog2(LOG_N_MAX_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } agu_state_e;

  function automatic logic logn_legal(input int unsigned log_n, input int unsigned log_n_max);
    return (log_n != 0) && (log_n <= log_n_max);
  endfunction

endpackage

// File: rtl/fft_wr_delay.sv
// Enable-gated shift register that lines up write-back addresses with butterfly
// results; it only advances when the datapath does.
module fft_wr_delay #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 21
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else if (en_i) begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_agu_pp.sv
// Radix-2 DIT FFT address generator over ping-pong banks with runtime size,
// inverse mode, downstream stall and latency-matched write-back addressing.
module fft_agu_pp
  import fft_pkg::*;
#(
  parameter int LOG_N_MAX = LOG_N_MAX_DEF,
  parameter int BFLY_LAT  = BFLY_LAT_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(LOG_N_MAX+1)-1:0] log_n,
  input  logic                           inverse,
  input  logic                           ready,
  output logic                           rd_valid,
  output logic [LOG_N_MAX-1:0]           rd_addr1,
  output logic [LOG_N_MAX-1:0]           rd_addr2,
  output logic [LOG_N_MAX-2:0]           tw_addr,
  output logic                           tw_conj,
  output logic                           rd_bank,
  output logic                           wr_en,
  output logic [LOG_N_MAX-1:0]           wr_addr1,
  output logic [LOG_N_MAX-1:0]           wr_addr2,
  output logic                           wr_bank,
  output logic [$clog2(LOG_N_MAX+1)-1:0] stage,
  output logic                           busy,
  output logic                           finish,
  output logic                           result_bank,
  output logic                           cfg_err
);

  localparam int AW  = LOG_N_MAX;
  localparam int TWW = LOG_N_MAX - 1;
  localparam int LW  = $clog2(LOG_N_MAX + 1);
  localparam int CW  = $clog2(BFLY_LAT + 1);
  localparam int DW  = 1 + 2 * AW;

  agu_state_e     state_q;
  logic [LW-1:0]  stage_q;
  logic [LW-1:0]  logn_q;
  logic [AW-1:0]  b_q;
  logic [CW-1:0]  cnt_q;
  logic           inv_q;
  logic           res_bank_q;
  logic           rd_valid_q;
  logic [AW-1:0]  rd_addr1_q;
  logic [AW-1:0]  rd_addr2_q;
  logic [TWW-1:0] tw_addr_q;
  logic           rd_bank_q;
  logic           wr_bank_q;
  logic           busy_q;
  logic           finish_q;
  logic           cfg_err_q;

  logic [AW-1:0]  b_nxt;
  logic [LW-1:0]  stage_nxt;
  logic           last_b;
  logic [DW-1:0]  dly_in;
  logic [DW-1:0]  dly_out;

  function automatic logic [AW-1:0] half_f(input logic [LW-1:0] s);
    return AW'(1) << s;
  endfunction

  // Upper address is b with a zero bit inserted at position s.
  function automatic logic [AW-1:0] addr1_f(input logic [LW-1:0] s, input logic [AW-1:0] b);
    return ((b >> s) << (s + LW'(1))) | (b & (half_f(s) - AW'(1)));
  endfunction

  // Twiddle index is scaled to the largest ROM, so it never depends on runtime N.
  function automatic logic [TWW-1:0] tw_f(input logic [LW-1:0] s, input logic [AW-1:0] b);
    logic [AW-1:0] k;
    k = b & (half_f(s) - AW'(1));
    return TWW'(k) << (LW'(TWW) - s);
  endfunction

  assign b_nxt     = b_q + AW'(1);
  assign stage_nxt = stage_q + LW'(1);
  assign last_b    = (b_q == ((AW'(1) << (logn_q - LW'(1))) - AW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      stage_q    <= '0;
      logn_q     <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      inv_q      <= 1'b0;
      res_bank_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
      tw_addr_q  <= '0;
      rd_bank_q  <= 1'b0;
      wr_bank_q  <= 1'b0;
      busy_q     <= 1'b0;
      finish_q   <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      finish_q  <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (logn_legal(int'(log_n), LOG_N_MAX)) begin
              logn_q     <= log_n;
              inv_q      <= inverse;
              res_bank_q <= log_n[0];
              stage_q    <= '0;
              b_q        <= '0;
              cnt_q      <= '0;
              rd_valid_q <= 1'b1;
              rd_addr1_q <= '0;
              rd_addr2_q <= AW'(1);
              tw_addr_q  <= '0;
              rd_bank_q  <= 1'b0;
              wr_bank_q  <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ready) begin
            if (last_b) begin
              rd_valid_q <= 1'b0;
              cnt_q      <= '0;
              state_q    <= DRAIN;
            end else begin
              b_q        <= b_nxt;
              rd_addr1_q <= addr1_f(stage_q, b_nxt);
              rd_addr2_q <= addr1_f(stage_q, b_nxt) + half_f(stage_q);
              tw_addr_q  <= tw_f(stage_q, b_nxt);
            end
          end
        end
        // Drain lets every write of this stage land before the next stage reads.
        DRAIN: begin
          if (ready) begin
            if (cnt_q == CW'(BFLY_LAT - 1)) begin
              if (stage_q < logn_q - LW'(1)) begin
                stage_q    <= stage_nxt;
                b_q        <= '0;
                rd_valid_q <= 1'b1;
                rd_addr1_q <= '0;
                rd_addr2_q <= half_f(stage_nxt);
                tw_addr_q  <= '0;
                rd_bank_q  <= stage_nxt[0];
                wr_bank_q  <= ~stage_nxt[0];
                state_q    <= RUN;
              end else begin
                busy_q   <= 1'b0;
                finish_q <= 1'b1;
                state_q  <= DONE;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dly_in = {rd_valid_q, rd_addr1_q, rd_addr2_q};

  fft_wr_delay #(
    .DEPTH(BFLY_LAT),
    .WIDTH(DW)
  ) u_wr_delay (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (ready),
    .d_i   (dly_in),
    .q_o   (dly_out)
  );

  assign wr_en       = dly_out[DW-1] & ready;
  assign wr_addr1    = dly_out[2*AW-1:AW];
  assign wr_addr2    = dly_out[AW-1:0];
  assign rd_valid    = rd_valid_q;
  assign rd_addr1    = rd_addr1_q;
  assign rd_addr2    = rd_addr2_q;
  assign tw_addr     = tw_addr_q;
  assign tw_conj     = inv_q;
  assign rd_bank     = rd_bank_q;
  assign wr_bank     = wr_bank_q;
  assign stage       = stage_q;
  assign busy        = busy_q;
  assign finish      = finish_q;
  assign result_bank = res_bank_q;
  assign cfg_err     = cfg_err_q;

endmodule
